// File: rtl/wino_pkg.sv
// wino_pkg: shared widths, lane types, FSM states and the block-count helper
package wino_pkg;
  localparam int WORD_W    = 512;
  localparam int LANES     = 64;
  localparam int OUT_LANES = 32;

  typedef logic signed [7:0]  int8;
  typedef logic signed [15:0] int16;
  typedef logic signed [19:0] acc20;

  typedef enum logic [2:0] {IDLE, LOAD, ACC, WRITE, DONE} state_e;

  // Number of 64-pixel blocks covering a w x h image, rounded up
  function automatic logic [12:0] blocks(input logic [8:0] w, input logic [8:0] h);
    logic [17:0] p;
    p = 18'(w) * 18'(h);
    return 13'((p + 18'd63) >> 6);
  endfunction
endpackage

// File: rtl/wino_mac_array.sv
// wino_mac_array: 64 signed 8x8 MACs with 20-bit accumulators, 16-bit conversion
// and optional ReLU. Define WINO_SAT_EN to saturate instead of wrapping.
module wino_mac_array
  import wino_pkg::*;
(
  input  logic              clk,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic              relu_i,
  input  logic [WORD_W-1:0] data_i,
  input  int8               w_i,
  output logic [WORD_W-1:0] res1_o,
  output logic [WORD_W-1:0] res2_o
);
  acc20 acc_q [LANES];

  // Per-lane accumulate; cleared at the start of every block
  always_ff @(posedge clk)
    for (int k = 0; k < LANES; k++)
      acc_q[k] <= clr_i ? '0 : en_i ? acc_q[k] + acc20'(int8'(data_i[8*k +: 8])) * acc20'(w_i) : acc_q[k];

  genvar k;
  for (k = 0; k < LANES; k++) begin : g_lane
    int16 cv;
`ifdef WINO_SAT_EN
    assign cv = (acc_q[k] > 20'sd32767) ? 16'sh7FFF : (acc_q[k] < -20'sd32768) ? 16'sh8000 : acc_q[k][15:0];
`else
    assign cv = acc_q[k][15:0];
`endif
    if (k < OUT_LANES) begin : g_lo
      assign res1_o[16*k +: 16] = (relu_i && cv[15]) ? '0 : cv;
    end else begin : g_hi
      assign res2_o[16*(k-OUT_LANES) +: 16] = (relu_i && cv[15]) ? '0 : cv;
    end
  end
endmodule

// File: rtl/wino_top.sv
// wino_top: pointwise int8 convolution engine with scan-loaded inputs and scan-read results
module wino_top #(
  parameter int DEPTH = 128,
  parameter int AW    = 8,
  parameter int LANES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           total_id,
  input  logic [7:0]           total_od,
  input  logic [8:0]           total_width,
  input  logic [8:0]           total_height,
  input  logic                 total_size_type,
  input  logic                 wen,
  input  logic                 input_mem_scan_mode,
  input  logic [1:0]           output_mem_scan_mode,
  input  logic [AW-1:0]        scan_addr,
  input  logic [8*LANES-1:0]   data_mem_scan_in,
  input  logic [8*LANES-1:0]   weight_mem_scan_in,
  output logic [8*LANES-1:0]   output_mem1_scan_out,
  output logic [8*LANES-1:0]   output_mem2_scan_out,
  output logic                 conv_completed
);
  import wino_pkg::*;

  localparam int MW = $clog2(DEPTH);

  logic [8*LANES-1:0] data_mem   [DEPTH];
  logic [8*LANES-1:0] weight_mem [DEPTH];
  logic [8*LANES-1:0] mem1       [DEPTH];
  logic [8*LANES-1:0] mem2       [DEPTH];

  state_e       state_q, state_d;
  logic [3:0]   id_q, id_d, c_q, c_d;
  logic [7:0]   od_q, od_d, o_q, o_d;
  logic [12:0]  nb_q, nb_d, b_q, b_d;
  logic         relu_q, relu_d;
  logic         clr, en, wr, bad;
  logic [12:0]  nb_in;
  logic [MW-1:0] rd_addr, wa;
  logic [8*LANES-1:0] data_q, res1, res2;
  logic [127:0] w_q;

  assign nb_in   = blocks(total_width, total_height);
  assign bad     = total_id == '0 || total_od == '0 || nb_in == '0 ||
                   20'(total_id) * 20'(nb_in) > 20'(DEPTH) || 20'(total_od) * 20'(nb_in) > 20'(DEPTH);
  // While accumulating channel c, prefetch channel c+1 of the same block
  assign rd_addr = MW'(state_q == ACC ? (20'(c_q) + 20'd1) * 20'(nb_q) + 20'(b_q) : 20'(b_q));
  assign wa      = MW'(20'(o_q) * 20'(nb_q) + 20'(b_q));
  assign conv_completed = state_q == DONE;

  // Next-state and loop-counter logic for the o/b/c iteration
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    od_d    = od_q;
    nb_d    = nb_q;
    relu_d  = relu_q;
    o_d     = o_q;
    b_d     = b_q;
    c_d     = c_q;
    clr     = 1'b0;
    en      = 1'b0;
    wr      = 1'b0;
    case (state_q)
      IDLE: if (wen && !input_mem_scan_mode && output_mem_scan_mode == 2'b01) begin
        id_d    = total_id;
        od_d    = total_od;
        nb_d    = nb_in;
        relu_d  = total_size_type;
        o_d     = '0;
        b_d     = '0;
        c_d     = '0;
        state_d = bad ? DONE : LOAD;
      end
      LOAD: begin
        clr     = 1'b1;
        c_d     = '0;
        state_d = ACC;
      end
      ACC: begin
        en      = 1'b1;
        c_d     = c_q + 4'd1;
        state_d = (c_q == id_q - 4'd1) ? WRITE : ACC;
      end
      WRITE: begin
        wr      = 1'b1;
        b_d     = (b_q == nb_q - 13'd1) ? '0 : b_q + 13'd1;
        o_d     = (b_q == nb_q - 13'd1) ? o_q + 8'd1 : o_q;
        state_d = (b_q == nb_q - 13'd1 && o_q == od_q - 8'd1) ? DONE : LOAD;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state with synchronous active-low reset; loop registers need no reset
  always_ff @(posedge clk) begin
    state_q <= reset_n ? state_d : IDLE;
    id_q    <= id_d;
    od_q    <= od_d;
    nb_q    <= nb_d;
    relu_q  <= relu_d;
    o_q     <= o_d;
    b_q     <= b_d;
    c_q     <= c_d;
  end

  // Scan-in writes are accepted regardless of reset; memories are never cleared
  always_ff @(posedge clk)
    if (input_mem_scan_mode && scan_addr < AW'(DEPTH)) begin
      data_mem[scan_addr[MW-1:0]]   <= data_mem_scan_in;
      weight_mem[scan_addr[MW-1:0]] <= weight_mem_scan_in;
    end

  // Synchronous compute reads: data every cycle, weights only when a block starts
  always_ff @(posedge clk) begin
    data_q <= data_mem[rd_addr];
    if (state_q == LOAD) w_q <= weight_mem[o_q[MW-1:0]][127:0];
  end

  wino_mac_array u_mac (
    .clk    (clk),
    .clr_i  (clr),
    .en_i   (en),
    .relu_i (relu_q),
    .data_i (data_q),
    .w_i    (int8'(w_q[{c_q, 3'b000} +: 8])),
    .res1_o (res1),
    .res2_o (res2)
  );

  // Both result halves land in one cycle, only while compute writes are enabled
  always_ff @(posedge clk)
    if (wr && output_mem_scan_mode == 2'b01) begin
      mem1[wa] <= res1;
      mem2[wa] <= res2;
    end

  // Registered scan-out; zero unless scan-out mode is selected
  always_ff @(posedge clk)
    if (!reset_n) begin
      output_mem1_scan_out <= '0;
      output_mem2_scan_out <= '0;
    end else begin
      output_mem1_scan_out <= output_mem_scan_mode == 2'b11 ? mem1[scan_addr[MW-1:0]] : '0;
      output_mem2_scan_out <= output_mem_scan_mode == 2'b11 ? mem2[scan_addr[MW-1:0]] : '0;
    end
endmodule

// File: tb/tb_wino_top.sv
// tb_wino_top: directed and randomized checks of wino_top against an arithmetic reference model
module tb_wino_top;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   total_id = '0;
  logic [7:0]   total_od = '0;
  logic [8:0]   total_width = '0, total_height = '0;
  logic         total_size_type = 1'b0, wen = 1'b0, input_mem_scan_mode = 1'b0;
  logic [1:0]   output_mem_scan_mode = 2'b00;
  logic [7:0]   scan_addr = '0;
  logic [511:0] data_mem_scan_in = '0, weight_mem_scan_in = '0;
  logic [511:0] out1, out2;
  logic         conv_completed;

  always #5 clk = ~clk;

  wino_top dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .total_id             (total_id),
    .total_od             (total_od),
    .total_width          (total_width),
    .total_height         (total_height),
    .total_size_type      (total_size_type),
    .wen                  (wen),
    .input_mem_scan_mode  (input_mem_scan_mode),
    .output_mem_scan_mode (output_mem_scan_mode),
    .scan_addr            (scan_addr),
    .data_mem_scan_in     (data_mem_scan_in),
    .weight_mem_scan_in   (weight_mem_scan_in),
    .output_mem1_scan_out (out1),
    .output_mem2_scan_out (out2),
    .conv_completed       (conv_completed)
  );

  int n_vec = 0, n_err = 0;
  logic [511:0] data_m [128], weight_m [128], mem1_m [128], mem2_m [128];
  bit valid_m [128];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  function automatic int nblk(input int w, input int h);
    return (w * h + 63) / 64;
  endfunction

  task automatic load(input int a, input logic [511:0] d, input logic [511:0] w);
    input_mem_scan_mode = 1'b1;
    scan_addr = 8'(a);
    data_mem_scan_in = d;
    weight_mem_scan_in = w;
    @(posedge clk); #1;
    input_mem_scan_mode = 1'b0;
    data_m[a] = d;
    weight_m[a] = w;
  endtask

  // Reference: out[o*B+b] pixel k = sum_c data[c*B+b][k] * weight[o][c], then convert
  task automatic model(input int id, input int od, input int w, input int h, input bit relu);
    int nb, acc, r;
    logic signed [7:0] dv, wv;
    logic [511:0] m1, m2;
    nb = nblk(w, h);
    if (id == 0 || od == 0 || nb == 0 || id * nb > 128 || od * nb > 128) return;
    for (int o = 0; o < od; o++)
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < 64; k++) begin
          acc = 0;
          for (int c = 0; c < id; c++) begin
            dv = data_m[c*nb + b][8*k +: 8];
            wv = weight_m[o][8*c +: 8];
            acc += int'(dv) * int'(wv);
          end
`ifdef WINO_SAT_EN
          r = acc > 32767 ? 32767 : acc < -32768 ? -32768 : acc;
`else
          r = int'(shortint'(acc));
`endif
          if (relu && r < 0) r = 0;
          if (k < 32) m1[16*k +: 16] = 16'(r);
          else m2[16*(k-32) +: 16] = 16'(r);
        end
        mem1_m[o*nb + b] = m1;
        mem2_m[o*nb + b] = m2;
        valid_m[o*nb + b] = 1'b1;
      end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wen = 1'b0;
    output_mem_scan_mode = 2'b11;
    @(posedge clk); #1;
    chk("rst_done", 512'(conv_completed), 512'd0);
    chk("rst_out1", out1, 512'd0);
    chk("rst_out2", out2, 512'd0);
    reset_n = 1'b1;
    output_mem_scan_mode = 2'b01;
  endtask

  task automatic run(input int id, input int od, input int w, input int h, input bit relu);
    int cyc, nb, exp_cyc;
    total_id = 4'(id);
    total_od = 8'(od);
    total_width = 9'(w);
    total_height = 9'(h);
    total_size_type = relu;
    output_mem_scan_mode = 2'b01;
    wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
    cyc = 1;
    while (!conv_completed && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    nb = nblk(w, h);
    exp_cyc = (id == 0 || od == 0 || nb == 0 || id * nb > 128 || od * nb > 128) ? 1 : od * nb * (id + 2) + 1;
    chk("done_flag", 512'(conv_completed), 512'd1);
    chk("latency", 512'(cyc), 512'(exp_cyc));
    model(id, od, w, h, relu);
  endtask

  task automatic scan(input int a);
    output_mem_scan_mode = 2'b11;
    scan_addr = 8'(a);
    @(posedge clk); #1;
  endtask

  task automatic check_all();
    for (int a = 0; a < 128; a++)
      if (valid_m[a]) begin
        scan(a);
        chk($sformatf("mem1[%0d]", a), out1, mem1_m[a]);
        chk($sformatf("mem2[%0d]", a), out2, mem2_m[a]);
      end
    output_mem_scan_mode = 2'b01;
  endtask

  initial begin
    int nb, id, od, w;
    bit relu;
    logic [511:0] expw;
    for (int a = 0; a < 128; a++) valid_m[a] = 1'b0;
    for (int a = 0; a < 128; a++) load(a, rnd512(), rnd512());
    do_reset();

    // Single channel, single block
    load(0, {64{8'h01}}, 512'h02);
    do_reset();
    run(1, 1, 8, 8, 1'b0);
    scan(0);
    chk("t1_mem1", out1, {32{16'h0002}});
    chk("t1_mem2", out2, {32{16'h0002}});
    check_all();

    // Two channels accumulated over 9 blocks and 4 output channels
    for (int a = 0; a < 18; a++)
      load(a, a < 9 ? {64{8'h03}} : {64{8'hFF}}, a < 4 ? 512'({8'd2, 8'(a + 1)}) : weight_m[a]);
    do_reset();
    run(2, 4, 24, 24, 1'b0);
    scan(35);
    chk("t2_o3b8", out1, {32{16'h000A}});
    check_all();

    // Sign and ReLU
    load(0, {64{8'h80}}, 512'h7F);
    do_reset();
    run(1, 1, 8, 8, 1'b0);
    scan(0);
    chk("t3_raw", out2, {32{16'hC080}});
    do_reset();
    run(1, 1, 8, 8, 1'b1);
    scan(0);
    chk("t3_relu", out1, 512'd0);

    // Accumulator beyond 16 bits
    for (int a = 0; a < 3; a++) load(a, {64{8'h80}}, a == 0 ? 512'h808080 : weight_m[a]);
    do_reset();
    run(3, 1, 8, 8, 1'b0);
    scan(0);
`ifdef WINO_SAT_EN
    expw = {32{16'h7FFF}};
`else
    expw = {32{16'hC000}};
`endif
    chk("t4_ovf", out1, expw);
    check_all();

    // Oversized config finishes at once and leaves results untouched
    do_reset();
    run(15, 15, 24, 24, 1'b0);
    check_all();

    // Start request during scan-in is ignored
    do_reset();
    total_id = 4'd1; total_od = 8'd1; total_width = 9'd8; total_height = 9'd8;
    output_mem_scan_mode = 2'b01;
    scan_addr = 8'd100;
    data_mem_scan_in = rnd512();
    weight_mem_scan_in = rnd512();
    data_m[100] = data_mem_scan_in;
    weight_m[100] = weight_mem_scan_in;
    input_mem_scan_mode = 1'b1;
    wen = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    wen = 1'b0;
    input_mem_scan_mode = 1'b0;
    chk("t6_idle", 512'(conv_completed), 512'd0);
    run(1, 1, 8, 8, 1'b1);
    check_all();

    // Reset mid-run, then a clean restart
    do_reset();
    total_id = 4'd4; total_od = 8'd8; total_width = 9'd32; total_height = 9'd32;
    wen = 1'b1;
    @(posedge clk); #1;
    wen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    run(4, 8, 32, 32, 1'b0);
    check_all();

    // Randomized configurations and memory contents
    for (int t = 0; t < 4; t++) begin
      for (int a = 0; a < 128; a++) load(a, rnd512(), rnd512());
      nb = $urandom_range(1, 16);
      id = $urandom_range(1, (128 / nb) < 15 ? 128 / nb : 15);
      od = $urandom_range(1, 128 / nb);
      w = $urandom_range(8 * nb - 7, 8 * nb);
      relu = 1'($urandom_range(0, 1));
      do_reset();
      run(id, od, w, 8, relu);
      check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
